// File: rtl/slideshow_controller.sv
// Slideshow controller: streams images from an SD byte source into the back frame buffer,
// then swaps buffers either directly (first load) or through a timed crossfade.
module slideshow_controller #(
   parameter int          H_RES       = 320,
   parameter int          V_RES       = 240,
   parameter int          BPP         = 2,
   parameter int          NUM_IMAGES  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'd0,
   parameter int          FADE_STEP   = 4,
   parameter int          FADE_DIV    = 65536,
   parameter int          AUTO_PERIOD = 0,
   parameter int          TIMEOUT     = 1000000,
   parameter int          MAX_RETRY   = 3,
   localparam int         IMG_BYTES   = H_RES * V_RES * BPP,
   localparam int         AW          = $clog2(H_RES * V_RES),
   localparam int         IW          = $clog2(NUM_IMAGES)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          btn_next,
   input  logic          btn_prev,
   input  logic          auto_en,
   input  logic          sd_busy,
   input  logic          sd_valid,
   input  logic [7:0]    sd_data,
   output logic          sd_start_read,
   output logic [31:0]   sd_read_addr,
   output logic          fb_we,
   output logic [AW-1:0] fb_waddr,
   output logic [23:0]   fb_wdata,
   output logic          fb_wsel,
   output logic          disp_buf,
   output logic          blend_en,
   output logic [7:0]    blend_factor,
   output logic [IW-1:0] image_index,
   output logic          err
);

   localparam int BW  = $clog2(IMG_BYTES + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int RW  = $clog2(MAX_RETRY + 2);
   localparam int DW  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam int APW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   typedef enum logic [2:0] {S_INIT, S_LOAD, S_XFADE, S_DISPLAY, S_ERROR} state_e;
   typedef enum logic [1:0] {REQ_NONE, REQ_NEXT, REQ_PREV} req_e;

   state_e          state_q, state_d;
   req_e            pend_q, pend_d;
   logic [IW-1:0]   img_q, img_d;
   logic [31:0]     addr_q, addr_d;
   logic            started_q, started_d;
   logic [BW-1:0]   byte_q, byte_d;
   logic [1:0]      lane_q, lane_d;
   logic [AW-1:0]   pix_q, pix_d;
   logic [15:0]     sh_q, sh_d;
   logic            we_q, we_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [23:0]     wdata_q, wdata_d;
   logic [TW-1:0]   to_q, to_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [DW-1:0]   div_q, div_d;
   logic [7:0]      bf_q, bf_d;
   logic            disp_q, disp_d;
   logic            loaded_q, loaded_d;
   logic [APW-1:0]  auto_q, auto_d;

   logic            enter_load, restart, go_next, go_prev, timeout;
   logic [8:0]      fade_sum;

   assign fade_sum      = {1'b0, bf_q} + 9'(FADE_STEP);
   assign sd_start_read = (state_q == S_LOAD) && !started_q && !sd_busy;
   assign sd_read_addr  = addr_q;
   assign fb_we         = we_q;
   assign fb_waddr      = waddr_q;
   assign fb_wdata      = wdata_q;
   assign fb_wsel       = ~disp_q;
   assign disp_buf      = disp_q;
   assign blend_en      = (state_q == S_XFADE);
   assign blend_factor  = bf_q;
   assign image_index   = img_q;
   assign err           = (state_q == S_ERROR);

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      img_d      = img_q;
      addr_d     = addr_q;
      started_d  = started_q;
      byte_d     = byte_q;
      lane_d     = lane_q;
      pix_d      = pix_q;
      sh_d       = sh_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      to_d       = to_q;
      retry_d    = retry_q;
      div_d      = div_q;
      bf_d       = bf_q;
      disp_d     = disp_q;
      loaded_d   = loaded_q;
      auto_d     = auto_q;
      enter_load = 1'b0;
      restart    = 1'b0;
      go_next    = 1'b0;
      go_prev    = 1'b0;
      timeout    = 1'b0;

      case (state_q)
         S_INIT: begin
            if (!sd_busy) enter_load = 1'b1;
         end
         S_LOAD: begin
            if (!started_q && !sd_busy) started_d = 1'b1;
            if (btn_next ^ btn_prev) pend_d = btn_next ? REQ_NEXT : REQ_PREV;
            if (sd_valid && (byte_q < BW'(IMG_BYTES))) begin
               byte_d = byte_q + 1'b1;
               sh_d   = {sh_q[7:0], sd_data};
               if (lane_q == 2'(BPP - 1)) begin
                  we_d    = 1'b1;
                  waddr_d = pix_q;
                  wdata_d = (BPP == 2) ? {8'h00, sh_q[7:0], sd_data} : {sh_q, sd_data};
                  pix_d   = pix_q + 1'b1;
                  lane_d  = '0;
               end else begin
                  lane_d  = lane_q + 1'b1;
               end
            end
            if (sd_valid)                        to_d = '0;
            else if (to_q == TW'(TIMEOUT - 1))   timeout = 1'b1;
            else                                 to_d = to_q + 1'b1;
            // Completion waits for the last pixel's write so it still targets the back buffer.
            if (we_q && (byte_q == BW'(IMG_BYTES))) begin
               retry_d = '0;
               if (!loaded_q) begin
                  loaded_d = 1'b1;
                  disp_d   = ~disp_q;
                  state_d  = S_DISPLAY;
               end else begin
                  div_d    = '0;
                  bf_d     = '0;
                  state_d  = S_XFADE;
               end
            end else if (timeout) begin
               if (retry_q >= RW'(MAX_RETRY)) begin
                  state_d = S_ERROR;
               end else begin
                  retry_d = retry_q + 1'b1;
                  restart = 1'b1;
               end
            end
         end
         S_XFADE: begin
            if (btn_next ^ btn_prev) pend_d = btn_next ? REQ_NEXT : REQ_PREV;
            if (bf_q == 8'hFF) begin
               disp_d  = ~disp_q;
               bf_d    = '0;
               state_d = S_DISPLAY;
            end else if (div_q == DW'(FADE_DIV - 1)) begin
               div_d = '0;
               bf_d  = fade_sum[8] ? 8'hFF : fade_sum[7:0];
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_DISPLAY: begin
            pend_d = REQ_NONE;
            if (btn_next || btn_prev) auto_d = '0;
            if (pend_q == REQ_NEXT)                      go_next = 1'b1;
            else if (pend_q == REQ_PREV)                 go_prev = 1'b1;
            else if (btn_next && !btn_prev)              go_next = 1'b1;
            else if (btn_prev && !btn_next)              go_prev = 1'b1;
            else if (!btn_next && !btn_prev && auto_en && (AUTO_PERIOD != 0)) begin
               if (auto_q == APW'(AUTO_PERIOD - 1)) go_next = 1'b1;
               else                                 auto_d  = auto_q + 1'b1;
            end
         end
         S_ERROR: begin
            if (btn_next && !btn_prev)      go_next = 1'b1;
            else if (btn_prev && !btn_next) go_prev = 1'b1;
         end
         default: state_d = S_INIT;
      endcase

      if (go_next) img_d = (img_q == IW'(NUM_IMAGES - 1)) ? '0 : img_q + 1'b1;
      if (go_prev) img_d = (img_q == '0) ? IW'(NUM_IMAGES - 1) : img_q - 1'b1;
      if (go_next || go_prev) enter_load = 1'b1;

      if (state_d != S_DISPLAY) auto_d = '0;

      if (enter_load || restart) begin
         started_d = 1'b0;
         byte_d    = '0;
         lane_d    = '0;
         pix_d     = '0;
         to_d      = '0;
      end
      if (enter_load) begin
         state_d = S_LOAD;
         retry_d = '0;
         addr_d  = BASE_ADDR + 32'(img_d) * 32'(IMG_BYTES);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_INIT;
         pend_q    <= REQ_NONE;
         img_q     <= '0;
         addr_q    <= '0;
         started_q <= 1'b0;
         byte_q    <= '0;
         lane_q    <= '0;
         pix_q     <= '0;
         sh_q      <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         to_q      <= '0;
         retry_q   <= '0;
         div_q     <= '0;
         bf_q      <= '0;
         disp_q    <= 1'b0;
         loaded_q  <= 1'b0;
         auto_q    <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         img_q     <= img_d;
         addr_q    <= addr_d;
         started_q <= started_d;
         byte_q    <= byte_d;
         lane_q    <= lane_d;
         pix_q     <= pix_d;
         sh_q      <= sh_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         to_q      <= to_d;
         retry_q   <= retry_d;
         div_q     <= div_d;
         bf_q      <= bf_d;
         disp_q    <= disp_d;
         loaded_q  <= loaded_d;
         auto_q    <= auto_d;
      end
   end

endmodule

// File: tb/tb_slideshow_controller.sv
// Directed bench for slideshow_controller on a 4x2 RGB565 image set of three images.
module tb_slideshow_controller;

   logic        clk = 1'b0;
   logic        reset_n, btn_next, btn_prev, auto_en, sd_busy, sd_valid;
   logic [7:0]  sd_data;
   logic        sd_start_read, fb_we, fb_wsel, disp_buf, blend_en, err;
   logic [31:0] sd_read_addr;
   logic [2:0]  fb_waddr;
   logic [23:0] fb_wdata;
   logic [7:0]  blend_factor;
   logic [1:0]  image_index;

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_start = 0;
   logic [2:0]  we_addr[$];
   logic [23:0] we_data[$];
   logic        we_sel[$];
   logic        exp_disp;

   always #5 clk = ~clk;

   slideshow_controller #(
      .H_RES(4), .V_RES(2), .BPP(2), .NUM_IMAGES(3),
      .FADE_STEP(64), .FADE_DIV(1), .TIMEOUT(20), .MAX_RETRY(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_next(btn_next), .btn_prev(btn_prev),
      .auto_en(auto_en), .sd_busy(sd_busy), .sd_valid(sd_valid), .sd_data(sd_data),
      .sd_start_read(sd_start_read), .sd_read_addr(sd_read_addr), .fb_we(fb_we),
      .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_wsel(fb_wsel), .disp_buf(disp_buf),
      .blend_en(blend_en), .blend_factor(blend_factor), .image_index(image_index), .err(err)
   );

   // Record every start pulse and frame-buffer write, sampled mid-cycle.
   always @(negedge clk) begin
      if (sd_start_read === 1'b1) n_start++;
      if (fb_we === 1'b1) begin
         we_addr.push_back(fb_waddr);
         we_data.push_back(fb_wdata);
         we_sel.push_back(fb_wsel);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic nxt, input logic prv);
      btn_next = nxt;
      btn_prev = prv;
      tick();
      btn_next = 1'b0;
      btn_prev = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (sd_start_read) seen = 1'b1;
      end
      check_val({tag, " start_pulse"}, 32'(seen), 32'd1);
      tick();
   endtask

   task automatic send_bytes(input logic [7:0] seed, input int n);
      for (int j = 0; j < n; j++) begin
         sd_valid = 1'b1;
         sd_data  = seed + 8'(j);
         tick();
      end
      sd_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input int idx, input int nbytes,
                           input logic [7:0] seed, input bit xfade, input bit press_in_fade);
      int   w0;
      logic wsel_exp;
      int   fade_exp[5];
      logic [7:0] b0, b1;
      fade_exp = '{0, 64, 128, 192, 255};
      w0       = we_addr.size();
      wsel_exp = ~exp_disp;
      wait_start(tag);
      check_val({tag, " addr"}, sd_read_addr, 32'(idx * 16));
      check_val({tag, " index"}, 32'(image_index), 32'(idx));
      send_bytes(seed, nbytes);
      tick();
      if (xfade) begin
         for (int k = 0; k < 5; k++) begin
            check_val({tag, " blend_en"}, 32'(blend_en), 32'd1);
            check_val({tag, " blend_factor"}, 32'(blend_factor), 32'(fade_exp[k]));
            if (press_in_fade && k == 1) btn_next = 1'b1;
            tick();
            btn_next = 1'b0;
         end
      end
      exp_disp = ~exp_disp;
      check_val({tag, " disp_buf"}, 32'(disp_buf), 32'(exp_disp));
      check_val({tag, " blend_en_off"}, 32'(blend_en), 32'd0);
      check_val({tag, " blend_factor_off"}, 32'(blend_factor), 32'd0);
      check_val({tag, " we_count"}, 32'(we_addr.size() - w0), 32'd8);
      if (we_addr.size() - w0 == 8) begin
         for (int p = 0; p < 8; p++) begin
            b0 = seed + 8'(2 * p);
            b1 = seed + 8'(2 * p + 1);
            check_val({tag, " waddr"}, 32'(we_addr[w0 + p]), 32'(p));
            check_val({tag, " wdata"}, 32'(we_data[w0 + p]), {8'h00, 8'h00, b0, b1});
            check_val({tag, " wsel"}, 32'(we_sel[w0 + p]), 32'(wsel_exp));
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, " start"}, 32'(sd_start_read), 32'd0);
      check_val({tag, " addr"}, sd_read_addr, 32'd0);
      check_val({tag, " fb_we"}, 32'(fb_we), 32'd0);
      check_val({tag, " waddr"}, 32'(fb_waddr), 32'd0);
      check_val({tag, " wdata"}, 32'(fb_wdata), 32'd0);
      check_val({tag, " wsel"}, 32'(fb_wsel), 32'd1);
      check_val({tag, " disp_buf"}, 32'(disp_buf), 32'd0);
      check_val({tag, " blend"}, {23'd0, blend_en, blend_factor}, 32'd0);
      check_val({tag, " index"}, 32'(image_index), 32'd0);
      check_val({tag, " err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1, w0;
      reset_n  = 1'b0;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      auto_en  = 1'b0;
      sd_busy  = 1'b0;
      sd_valid = 1'b0;
      sd_data  = 8'h00;
      exp_disp = 1'b0;
      tick(2);
      check_reset_outputs("reset");

      // V1: first load, two surplus bytes must not write
      reset_n = 1'b1;
      s0 = n_start;
      run_load("v1", 0, 18, 8'h00, 1'b0, 1'b0);
      check_val("v1 one_start", 32'(n_start - s0), 32'd1);
      check_val("v1 first_wdata", 32'(we_data[0]), 32'h000001);

      // V2: next image with crossfade
      press(1'b1, 1'b0);
      run_load("v2", 1, 16, 8'h40, 1'b1, 1'b0);

      // V3: previous three times, wrapping 0 -> 2
      press(1'b0, 1'b1);
      run_load("v3a", 0, 16, 8'h80, 1'b1, 1'b0);
      press(1'b0, 1'b1);
      run_load("v3b", 2, 16, 8'h90, 1'b1, 1'b0);
      press(1'b0, 1'b1);
      run_load("v3c", 1, 16, 8'hA0, 1'b1, 1'b0);

      // V4: request during fade is served once; simultaneous pair ignored
      press(1'b1, 1'b0);
      run_load("v4a", 2, 16, 8'hB0, 1'b1, 1'b1);
      s1 = n_start;
      run_load("v4b", 0, 16, 8'hC0, 1'b1, 1'b0);
      check_val("v4 pending_once", 32'(n_start - s1), 32'd1);
      press(1'b1, 1'b1);
      tick(10);
      check_val("v4 pair_no_start", 32'(n_start - s1), 32'd1);
      check_val("v4 pair_index", 32'(image_index), 32'd0);
      check_val("v4 pair_disp", 32'(disp_buf), 32'(exp_disp));

      // V5: two silent attempts lead to ERROR, a button recovers
      s0 = n_start;
      press(1'b1, 1'b0);
      tick(29);
      check_val("v5 starts_mid", 32'(n_start - s0), 32'd2);
      check_val("v5 err_mid", 32'(err), 32'd0);
      tick(15);
      check_val("v5 starts_end", 32'(n_start - s0), 32'd2);
      check_val("v5 err_set", 32'(err), 32'd1);
      check_val("v5 err_index", 32'(image_index), 32'd1);
      check_val("v5 err_disp", 32'(disp_buf), 32'(exp_disp));
      press(1'b1, 1'b0);
      check_val("v5 err_clear", 32'(err), 32'd0);
      run_load("v5", 2, 16, 8'hD0, 1'b1, 1'b0);

      // V6: reset in the middle of a load
      press(1'b1, 1'b0);
      wait_start("v6pre");
      send_bytes(8'hE0, 5);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("v6 async");
      s0 = n_start;
      w0 = we_addr.size();
      tick(3);
      sd_busy = 1'b1;
      reset_n = 1'b1;
      tick(4);
      check_val("v6 no_start", 32'(n_start - s0), 32'd0);
      check_val("v6 no_we", 32'(we_addr.size() - w0), 32'd0);
      sd_busy  = 1'b0;
      exp_disp = 1'b0;
      run_load("v6", 0, 16, 8'hF0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
